// File: rtl/probe_tap_serializer.sv
// Probe read-out: snapshots NUM_TAPS probe words and streams them LSB-first over a 1-bit valid/ready link.
// Latency: first bit is valid the cycle after an accepted capture; back-to-back frames have no gap.
// Backpressure: O, O_last and bit position hold while O_ready is low; O_valid is never withdrawn mid-frame.
module probe_tap_serializer #(
   parameter int NUM_TAPS  = 4,
   parameter int TAP_WIDTH = 8
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [NUM_TAPS*TAP_WIDTH-1:0] taps,
   input  logic                          capture_req,
   output logic                          busy,
   output logic                          O,
   output logic                          O_valid,
   input  logic                          O_ready,
   output logic                          O_last,
   output logic                          overrun,
   output logic [7:0]                    frame_count
);

   localparam int TOTAL = NUM_TAPS * TAP_WIDTH;
   localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state_q;
   logic [TOTAL-1:0]  shadow_q;
   logic [CW-1:0]     bit_cnt_q;
   logic              overrun_q;
   logic [7:0]        frame_count_q;

   logic              in_shift;
   logic              on_last;

   assign in_shift = (state_q == SHIFT);
   assign on_last  = (bit_cnt_q == LAST_IDX);

   // Frame sequencing: capture, per-bit advance on handshake, back-to-back reload, overrun tracking.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= IDLE;
         shadow_q      <= '0;
         bit_cnt_q     <= '0;
         overrun_q     <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (capture_req) begin
                  shadow_q  <= taps;
                  bit_cnt_q <= '0;
                  overrun_q <= 1'b0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (O_ready && on_last) begin
                  frame_count_q <= frame_count_q + 8'd1;
                  if (capture_req) begin
                     // Reload in the same edge so the next frame starts without an idle cycle.
                     shadow_q  <= taps;
                     bit_cnt_q <= '0;
                     overrun_q <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  if (O_ready) begin
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end
                  // A request that cannot be honoured is dropped; the shadow stays intact.
                  if (capture_req) begin
                     overrun_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Link outputs are pure functions of the registered state, independent of O_ready.
   always_comb begin
      busy        = in_shift;
      O_valid     = in_shift;
      O           = in_shift ? shadow_q[bit_cnt_q] : 1'b0;
      O_last      = in_shift && on_last;
      overrun     = overrun_q;
      frame_count = frame_count_q;
   end

endmodule

// File: tb/tb_probe_tap_serializer.sv
// Bench for probe_tap_serializer: an 8-bit frame instance (2x4) and a single-bit frame instance (1x1).
// Table of per-cycle vectors plus directed sequences for reset, wrap and single-bit frames.
// Outputs are sampled on the falling edge; inputs are driven just after it.
module tb_probe_tap_serializer;

   logic       clk;
   logic       rst;

   logic [7:0] taps;
   logic       req;
   logic       rdy;
   logic       busy, o, o_valid, o_last, ovr;
   logic [7:0] fc;

   logic [0:0] taps1;
   logic       req1;
   logic       rdy1;
   logic       busy1, o1, o_valid1, o_last1, ovr1;
   logic [7:0] fc1;

   int total;
   int bad;

   probe_tap_serializer #(.NUM_TAPS(2), .TAP_WIDTH(4)) u_dut (
      .CLK         (clk),
      .RESET       (rst),
      .taps        (taps),
      .capture_req (req),
      .busy        (busy),
      .O           (o),
      .O_valid     (o_valid),
      .O_ready     (rdy),
      .O_last      (o_last),
      .overrun     (ovr),
      .frame_count (fc)
   );

   probe_tap_serializer #(.NUM_TAPS(1), .TAP_WIDTH(1)) u_dut1 (
      .CLK         (clk),
      .RESET       (rst),
      .taps        (taps1),
      .capture_req (req1),
      .busy        (busy1),
      .O           (o1),
      .O_valid     (o_valid1),
      .O_ready     (rdy1),
      .O_last      (o_last1),
      .overrun     (ovr1),
      .frame_count (fc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output packing: {O, O_valid, O_last, busy, overrun, frame_count[7:0]}
   typedef struct {
      logic        req;
      logic        rdy;
      logic [7:0]  taps;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic y, input logic [7:0] t,
                      input logic eo, input logic ev, input logic el, input logic eb,
                      input logic eov, input logic [7:0] efc);
      vec_t v;
      v.req  = r;
      v.rdy  = y;
      v.taps = t;
      v.exp  = {eo, ev, el, eb, eov, efc};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] snap0();
      return {o, o_valid, o_last, busy, ovr, fc};
   endfunction

   function automatic logic [12:0] snap1();
      return {o1, o_valid1, o_last1, busy1, ovr1, fc1};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   int gaps;
   int last_err;

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      taps  = 8'h00;
      req   = 1'b0;
      rdy   = 1'b0;
      taps1 = 1'b0;
      req1  = 1'b0;
      rdy1  = 1'b0;

      // Test 1: plain frame of A5 with ready held high
      add(1,1,8'hA5, 1,1,0,1,0,8'd0);
      add(0,1,8'hA5, 0,1,0,1,0,8'd0);
      add(0,1,8'hA5, 1,1,0,1,0,8'd0);
      add(0,1,8'hA5, 0,1,0,1,0,8'd0);
      add(0,1,8'hA5, 0,1,0,1,0,8'd0);
      add(0,1,8'hA5, 1,1,0,1,0,8'd0);
      add(0,1,8'hA5, 0,1,0,1,0,8'd0);
      add(0,1,8'hA5, 1,1,1,1,0,8'd0);
      add(0,1,8'hA5, 0,0,0,0,0,8'd1);
      // Test 2: ready stalls, taps change to FF mid-frame
      add(1,0,8'hA5, 1,1,0,1,0,8'd1);
      add(0,1,8'hA5, 0,1,0,1,0,8'd1);
      add(0,0,8'hA5, 0,1,0,1,0,8'd1);
      add(0,0,8'hFF, 0,1,0,1,0,8'd1);
      add(0,1,8'hFF, 1,1,0,1,0,8'd1);
      add(0,0,8'hFF, 1,1,0,1,0,8'd1);
      add(0,1,8'hFF, 0,1,0,1,0,8'd1);
      add(0,1,8'hFF, 0,1,0,1,0,8'd1);
      add(0,0,8'hFF, 0,1,0,1,0,8'd1);
      add(0,1,8'hFF, 1,1,0,1,0,8'd1);
      add(0,1,8'hFF, 0,1,0,1,0,8'd1);
      add(0,0,8'hFF, 0,1,0,1,0,8'd1);
      add(0,1,8'hFF, 1,1,1,1,0,8'd1);
      add(0,0,8'hFF, 1,1,1,1,0,8'd1);
      add(0,1,8'hFF, 0,0,0,0,0,8'd2);
      // Test 3: request at bit 3 sets sticky overrun, frame continues untouched
      add(1,1,8'hA5, 1,1,0,1,0,8'd2);
      add(0,1,8'hA5, 0,1,0,1,0,8'd2);
      add(0,1,8'hA5, 1,1,0,1,0,8'd2);
      add(0,1,8'hA5, 0,1,0,1,0,8'd2);
      add(1,0,8'h3C, 0,1,0,1,1,8'd2);
      add(1,1,8'h3C, 0,1,0,1,1,8'd2);
      add(0,1,8'h3C, 1,1,0,1,1,8'd2);
      add(0,1,8'h3C, 0,1,0,1,1,8'd2);
      add(0,1,8'h3C, 1,1,1,1,1,8'd2);
      // Test 4: capture on last-bit handshake -> back-to-back 3C frame, overrun cleared
      add(1,1,8'h3C, 0,1,0,1,0,8'd3);
      add(0,1,8'h3C, 0,1,0,1,0,8'd3);
      add(0,1,8'h3C, 1,1,0,1,0,8'd3);
      add(0,1,8'h3C, 1,1,0,1,0,8'd3);
      add(0,1,8'h3C, 1,1,0,1,0,8'd3);
      add(0,1,8'h3C, 1,1,0,1,0,8'd3);

      tick();
      tick();
      chk("reset_state", 32'(snap0()), 32'(13'h0000));
      chk("reset_state_1bit", 32'(snap1()), 32'(13'h0000));
      rst = 1'b0;

      foreach (vecs[i]) begin
         req  = vecs[i].req;
         rdy  = vecs[i].rdy;
         taps = vecs[i].taps;
         tick();
         chk($sformatf("vec[%0d]", i), 32'(snap0()), 32'(vecs[i].exp));
      end

      // Test 5: reset mid-frame at bit 5 discards the frame and clears the counter
      req = 1'b0;
      rdy = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midframe_reset", 32'(snap0()), 32'(13'h0000));
      req  = 1'b1;
      rdy  = 1'b0;
      taps = 8'hA5;
      tick();
      chk("restart_bit0", 32'(snap0()), 32'({1'b1,1'b1,1'b0,1'b1,1'b0,8'd0}));
      req = 1'b0;
      rdy = 1'b1;
      tick();
      chk("restart_bit1", 32'(snap0()), 32'({1'b0,1'b1,1'b0,1'b1,1'b0,8'd0}));

      // Test 6: 256 back-to-back frames, frame_count wraps to 0
      rst = 1'b1;
      req = 1'b0;
      tick();
      rst = 1'b0;
      req = 1'b1;
      rdy = 1'b1;
      tick();
      gaps     = 0;
      last_err = 0;
      for (int f = 0; f < 256; f++) begin
         for (int b = 0; b < 8; b++) begin
            req = (b == 7) && (f != 255);
            rdy = 1'b1;
            tick();
            if (!(b == 7 && f == 255)) begin
               if (o_valid !== 1'b1) gaps++;
               if (o_last !== (b == 6)) last_err++;
            end
            if (f == 254 && b == 7) begin
               chk("fc_at_255", 32'(fc), 32'd255);
            end
         end
      end
      chk("b2b_no_gap", gaps, 0);
      chk("b2b_last_pos", last_err, 0);
      chk("fc_wrap", 32'(snap0()), 32'(13'h0000));
      req = 1'b0;
      rdy = 1'b0;

      // Single-bit frames: every valid bit is also the last
      req1  = 1'b1;
      taps1 = 1'b1;
      rdy1  = 1'b0;
      tick();
      chk("t1_first", 32'(snap1()), 32'({1'b1,1'b1,1'b1,1'b1,1'b0,8'd0}));
      req1 = 1'b0;
      tick();
      chk("t1_hold", 32'(snap1()), 32'({1'b1,1'b1,1'b1,1'b1,1'b0,8'd0}));
      req1  = 1'b1;
      taps1 = 1'b0;
      rdy1  = 1'b1;
      tick();
      chk("t1_b2b", 32'(snap1()), 32'({1'b0,1'b1,1'b1,1'b1,1'b0,8'd1}));
      req1 = 1'b0;
      tick();
      chk("t1_idle", 32'(snap1()), 32'({1'b0,1'b0,1'b0,1'b0,1'b0,8'd2}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
